// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer.
package calc_pkg;

    localparam int OP_W = 2;

    // Operation select encoding driven onto the result mux
    localparam logic [OP_W-1:0] OP_ADD = 2'd0;
    localparam logic [OP_W-1:0] OP_SUB = 2'd1;
    localparam logic [OP_W-1:0] OP_AND = 2'd2;
    localparam logic [OP_W-1:0] OP_OR  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_WAIT_B = 3'd2,
        ST_LOAD_B = 3'd3,
        ST_EXEC   = 3'd4,
        ST_SHOW   = 3'd5
    } state_e;

endpackage

// File: rtl/calc_sequencer_pb_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and
// rising-edge detect. A level is accepted only after DB_CYCLES consecutive
// synchronized samples disagree with the current debounced level.
module pb_debounce #(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_raw,
    output logic press
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic          level_q;
    logic [CW-1:0] cnt;

    // Synchronize, count disagreeing cycles and flip the accepted level on terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= pb_raw;
            sync_2  <= sync_1;
            level_q <= level;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Only a press (0->1 of the accepted level) produces a pulse
    assign press = level & ~level_q;

endmodule

// File: rtl/calc_sequencer.sv
// Calculator control: conditions the three buttons and sequences
// operand load / execute / display, owning the operation select.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | nothing loaded, waiting for first step
//   LOAD_A  | one-cycle strobe capturing operand A
//   WAIT_B  | waiting for step to capture operand B
//   LOAD_B  | one-cycle strobe capturing operand B
//   EXEC    | one-cycle strobe registering the result
//   SHOW    | result displayed; step restarts, op re-executes
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pb_step,
    input  logic            pb_op,
    input  logic            pb_clr,
    output logic [OP_W-1:0] op_sel,
    output logic            load_a,
    output logic            load_b,
    output logic            exec,
    output logic            result_valid,
    output logic [2:0]      state
);

    logic            step_p;
    logic            op_p;
    logic            clr_p;

    state_e          st_q;
    state_e          st_d;
    logic [OP_W-1:0] op_d;
    logic            pend_q;
    logic            pend_d;
    logic            op_req;

    pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_step (
        .clk    (clk),
        .rst    (rst),
        .pb_raw (pb_step),
        .press  (step_p)
    );

    pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_op (
        .clk    (clk),
        .rst    (rst),
        .pb_raw (pb_op),
        .press  (op_p)
    );

    pb_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
        .clk    (clk),
        .rst    (rst),
        .pb_raw (pb_clr),
        .press  (clr_p)
    );

    // In SHOW a fresh op press and one deferred from LOAD_B/EXEC act alike
    assign op_req = op_p | pend_q;

    // Next state, op select and deferred-op flag; clr overrides step, step overrides op
    always_comb begin
        st_d   = st_q;
        op_d   = op_sel;
        pend_d = pend_q;
        if (clr_p) begin
            st_d   = ST_IDLE;
            pend_d = 1'b0;
        end else begin
            case (st_q)
                ST_IDLE: begin
                    if (op_p)   op_d = op_sel + 1'b1;
                    if (step_p) st_d = ST_LOAD_A;
                end
                ST_LOAD_A: begin
                    if (op_p) op_d = op_sel + 1'b1;
                    st_d = ST_WAIT_B;
                end
                ST_WAIT_B: begin
                    if (op_p)   op_d = op_sel + 1'b1;
                    if (step_p) st_d = ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    // op_sel must stay put while the datapath is mid-computation
                    if (op_p) pend_d = 1'b1;
                    st_d = ST_EXEC;
                end
                ST_EXEC: begin
                    if (op_p) pend_d = 1'b1;
                    st_d = ST_SHOW;
                end
                ST_SHOW: begin
                    if (op_req) begin
                        op_d   = op_sel + 1'b1;
                        pend_d = 1'b0;
                    end
                    if (step_p)      st_d = ST_LOAD_A;
                    else if (op_req) st_d = ST_EXEC;
                end
                default: st_d = ST_IDLE;
            endcase
        end
    end

    // State, op select and pending flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= ST_IDLE;
            op_sel <= OP_ADD;
            pend_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            op_sel <= op_d;
            pend_q <= pend_d;
        end
    end

    assign load_a       = (st_q == ST_LOAD_A);
    assign load_b       = (st_q == ST_LOAD_B);
    assign exec         = (st_q == ST_EXEC);
    assign result_valid = (st_q == ST_SHOW);
    assign state        = st_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: reset, table-driven press walk, hand-written
// multi-cycle corner cases, then randomized buttons against a reference model.
module tb_calc_sequencer;

    localparam int DB = 16;

    localparam int S_IDLE = 0, S_LOAD_A = 1, S_WAIT_B = 2, S_LOAD_B = 3, S_EXEC = 4, S_SHOW = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pb_step = 1'b0;
    logic       pb_op = 1'b0;
    logic       pb_clr = 1'b0;
    logic [1:0] op_sel;
    logic       load_a, load_b, exec, result_valid;
    logic [2:0] state;

    int total = 0;
    int bad = 0;

    calc_sequencer #(.DB_CYCLES(DB)) dut (
        .clk          (clk),
        .rst          (rst),
        .pb_step      (pb_step),
        .pb_op        (pb_op),
        .pb_clr       (pb_clr),
        .op_sel       (op_sel),
        .load_a       (load_a),
        .load_b       (load_b),
        .exec         (exec),
        .result_valid (result_valid),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Hold the given buttons for 24 cycles, release, watch 60 cycles in all
    task automatic run_press(input logic s, input logic o, input logic c,
                             output int la, output int lb, output int ex);
        la = 0; lb = 0; ex = 0;
        pb_step = s; pb_op = o; pb_clr = c;
        for (int i = 0; i < 60; i++) begin
            if (i == 24) begin
                pb_step = 1'b0; pb_op = 1'b0; pb_clr = 1'b0;
            end
            @(posedge clk); #1;
            la += int'(load_a);
            lb += int'(load_b);
            ex += int'(exec);
        end
    endtask

    // ---------------- reference model ----------------
    // A button level is accepted once the last DB synchronized samples all
    // disagree with it; synchronized sample at edge e is the raw input at e-2.
    int         m_state, m_op, m_pend;
    logic [2:0] m_lvl, m_lvlq;
    logic [19:0] m_hist [3];

    function automatic void m_reset();
        m_state = S_IDLE; m_op = 0; m_pend = 0;
        m_lvl = '0; m_lvlq = '0;
        for (int b = 0; b < 3; b++) m_hist[b] = '0;
    endfunction

    function automatic void m_fsm(logic stp, logic opp, logic clp);
        if (clp) begin
            m_state = S_IDLE;
            m_pend  = 0;
            return;
        end
        case (m_state)
            S_IDLE, S_WAIT_B: begin
                if (opp) m_op = (m_op + 1) % 4;
                if (stp) m_state = (m_state == S_IDLE) ? S_LOAD_A : S_LOAD_B;
            end
            S_LOAD_A: begin
                if (opp) m_op = (m_op + 1) % 4;
                m_state = S_WAIT_B;
            end
            S_LOAD_B, S_EXEC: begin
                if (opp) m_pend = 1;
                m_state = m_state + 1;
            end
            S_SHOW: begin
                if (opp || m_pend != 0) begin
                    m_op = (m_op + 1) % 4;
                    m_pend = 0;
                    m_state = stp ? S_LOAD_A : S_EXEC;
                end else if (stp) begin
                    m_state = S_LOAD_A;
                end
            end
            default: m_state = S_IDLE;
        endcase
    endfunction

    function automatic void m_edge(logic r, logic [2:0] raw);
        logic [2:0] pr;
        if (r) begin
            m_reset();
            return;
        end
        pr = m_lvl & ~m_lvlq;
        m_fsm(pr[0], pr[1], pr[2]);
        m_lvlq = m_lvl;
        for (int b = 0; b < 3; b++) begin
            m_hist[b] = {m_hist[b][18:0], raw[b]};
            if (m_hist[b][17:2] == (m_lvl[b] ? 16'h0000 : 16'hffff))
                m_lvl[b] = ~m_lvl[b];
        end
    endfunction

    // ---------------- table ----------------
    typedef struct {
        logic s, o, c;
        int   st, op, la, lb, ex;
    } vec_t;

    vec_t vecs [12];

    initial begin
        int la, lb, ex;
        int first, cnt, ex1_op, ex2_op, nex;
        int lb_at, ex_at, rv_at;
        logic [2:0] lv;
        int rem [3];
        logic [8:0] got, want;

        vecs[0]  = '{1'b0, 1'b1, 1'b0, S_IDLE,   1, 0, 0, 0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, S_IDLE,   2, 0, 0, 0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, S_IDLE,   3, 0, 0, 0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, S_IDLE,   0, 0, 0, 0};
        vecs[4]  = '{1'b1, 1'b0, 1'b0, S_WAIT_B, 0, 1, 0, 0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, S_WAIT_B, 1, 0, 0, 0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, S_SHOW,   1, 0, 1, 1};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, S_SHOW,   2, 0, 0, 1};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, S_WAIT_B, 3, 1, 0, 0};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, S_IDLE,   3, 0, 0, 0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, S_WAIT_B, 3, 1, 0, 0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, S_IDLE,   3, 0, 0, 0};

        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst state", int'(state), 0);
        check("rst op_sel", int'(op_sel), 0);
        check("rst load_a", int'(load_a), 0);
        check("rst load_b", int'(load_b), 0);
        check("rst exec", int'(exec), 0);
        check("rst result_valid", int'(result_valid), 0);
        rst = 1'b0;

        // table walk
        for (int i = 0; i < 12; i++) begin
            run_press(vecs[i].s, vecs[i].o, vecs[i].c, la, lb, ex);
            check($sformatf("vec%0d state", i), int'(state), vecs[i].st);
            check($sformatf("vec%0d op_sel", i), int'(op_sel), vecs[i].op);
            check($sformatf("vec%0d load_a cnt", i), la, vecs[i].la);
            check($sformatf("vec%0d load_b cnt", i), lb, vecs[i].lb);
            check($sformatf("vec%0d exec cnt", i), ex, vecs[i].ex);
        end

        // bounce: 5 on / 3 off x4 never accepted, then clean hold
        cnt = 0;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 8; j++) begin
                pb_step = (j < 5);
                @(posedge clk); #1;
                cnt += int'(load_a);
            end
        end
        check("bounce no load_a", cnt, 0);
        first = -1;
        pb_step = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 20) pb_step = 1'b0;
            @(posedge clk); #1;
            if (load_a) begin
                cnt++;
                if (first < 0) first = i + 1;
            end
        end
        check("bounce load_a count", cnt, 1);
        // held before edge k; load_a visible after edge k+18, the 19th edge counted
        check("bounce load_a latency", first, 19);

        // step in WAIT_B: load_b, exec, result_valid on consecutive cycles
        lb_at = -1; ex_at = -1; rv_at = -1;
        pb_step = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 24) pb_step = 1'b0;
            @(posedge clk); #1;
            if (load_b && lb_at < 0) lb_at = i;
            if (exec && ex_at < 0) ex_at = i;
            if (result_valid && rv_at < 0) rv_at = i;
        end
        check("chain load_b seen", int'(lb_at >= 0), 1);
        check("chain exec gap", ex_at - lb_at, 1);
        check("chain rv gap", rv_at - lb_at, 2);
        check("chain rv held", int'(result_valid), 1);

        run_press(1'b1, 1'b0, 1'b0, la, lb, ex);
        check("restart load_a", la, 1);
        check("restart rv low", int'(result_valid), 0);

        run_press(1'b0, 1'b1, 1'b0, la, lb, ex);
        run_press(1'b0, 1'b1, 1'b0, la, lb, ex);
        check("waitb op wrap", int'(op_sel), 1);
        run_press(1'b1, 1'b0, 1'b0, la, lb, ex);
        check("to show", int'(state), S_SHOW);

        // re-execute from SHOW
        run_press(1'b0, 1'b1, 1'b0, la, lb, ex);
        check("reexec op_sel", int'(op_sel), 2);
        check("reexec exec cnt", ex, 1);
        check("reexec state", int'(state), S_SHOW);

        // op press landing in LOAD_B is deferred to SHOW
        run_press(1'b1, 1'b0, 1'b0, la, lb, ex);
        nex = 0; ex1_op = -1; ex2_op = -1;
        pb_step = 1'b1;
        @(posedge clk); #1;
        pb_op = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (i == 24) begin
                pb_step = 1'b0; pb_op = 1'b0;
            end
            @(posedge clk); #1;
            if (exec) begin
                nex++;
                if (nex == 1) ex1_op = int'(op_sel);
                if (nex == 2) ex2_op = int'(op_sel);
            end
        end
        check("pending exec cnt", nex, 2);
        check("pending op at exec1", ex1_op, 2);
        check("pending op at exec2", ex2_op, 3);
        check("pending end state", int'(state), S_SHOW);

        // reset in the EXEC cycle with step held through it
        pb_op = 1'b1;
        begin
            int waited = 0;
            while (!exec && waited < 60) begin
                @(posedge clk); #1;
                waited++;
            end
            check("reach exec", int'(exec), 1);
        end
        rst = 1'b1; pb_op = 1'b0; pb_step = 1'b1;
        @(posedge clk); #1;
        check("midrst exec", int'(exec), 0);
        check("midrst state", int'(state), S_IDLE);
        check("midrst op_sel", int'(op_sel), 0);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (i == 30) pb_step = 1'b0;
            @(posedge clk); #1;
            cnt += int'(load_a);
        end
        check("midrst load_a cnt", cnt, 1);

        // randomized buttons against the reference model
        lv = '0;
        rem[0] = 0; rem[1] = 0; rem[2] = 0;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            logic r;
            for (int b = 0; b < 3; b++) begin
                if (rem[b] == 0) begin
                    if (b == 2) lv[b] = ($urandom_range(0, 7) == 0);
                    else        lv[b] = ($urandom_range(0, 1) == 1);
                    rem[b] = int'($urandom_range(3, 45));
                end else begin
                    rem[b]--;
                end
            end
            r = (c == 0) || ($urandom_range(0, 399) == 0);
            rst = r; pb_step = lv[0]; pb_op = lv[1]; pb_clr = lv[2];
            @(posedge clk);
            m_edge(r, lv);
            #1;
            got  = {state, op_sel, load_a, load_b, exec, result_valid};
            want = {3'(m_state), 2'(m_op), m_state == S_LOAD_A, m_state == S_LOAD_B,
                    m_state == S_EXEC, m_state == S_SHOW};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL rand cyc %0d: got=%h want=%h", c, got, want);
            end
        end
        rst = 1'b0; pb_step = 1'b0; pb_op = 1'b0; pb_clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control block for the simple calculator. Debounces the three push-buttons, steps the operand-load / execute / display sequence and owns the 2-bit operation select that drives the result mux. It replaces free-running button-clocked op selection with a single-clock, synchronously reset controller. The datapath consumes its one-cycle strobes.

## Interface
- DB_CYCLES, 16: consecutive stable synchronized cycles before a button level is accepted. Board build overrides this to about 1_000_000.
- clk  in  1  system clock; every flop is on its rising edge
- rst  in  1  synchronous, active-high reset
- pb_step  in  1  raw, asynchronous button: advance the sequence
- pb_op  in  1  raw button: cycle the operation select
- pb_clr  in  1  raw button: abort to idle
- op_sel  out  2  operation select to the result mux
- load_a  out  1  one-cycle strobe: capture operand A
- load_b  out  1  one-cycle strobe: capture operand B
- exec  out  1  one-cycle strobe: register the result using op_sel
- result_valid  out  1  high while the displayed result is current
- state  out  3  encoded FSM state, for debug LEDs

## Operation
- **Button path.** Each button goes through:
  - a 2-flop synchronizer,
  - then a stability counter: while the synced value differs from the debounced level, count up; on the count reaching DB_CYCLES-1, flip the debounced level and zero the counter; any return to equality zeroes the counter,
  - then a rising-edge detect, giving a one-cycle press pulse. Release produces no pulse.
- **States:** IDLE=0, LOAD_A=1, WAIT_B=2, LOAD_B=3, EXEC=4, SHOW=5.
- **Transitions:**
  - IDLE + step → LOAD_A
  - LOAD_A → WAIT_B (unconditional)
  - WAIT_B + step → LOAD_B
  - LOAD_B → EXEC
  - EXEC → SHOW
  - SHOW + step → LOAD_A
  - SHOW + op → EXEC (re-execute with the new op)
- **Outputs are Moore:**
  - load_a = (state==LOAD_A)
  - load_b = (state==LOAD_B)
  - exec = (state==EXEC)
  - result_valid = (state==SHOW)
- **op press handling.**
  - In IDLE, LOAD_A, WAIT_B or SHOW: op_sel <= op_sel+1, mod 4 (3 wraps to 0).
  - In LOAD_B or EXEC, op_sel is frozen. The press sets a pending flag instead.
  - The pending flag is applied on the first SHOW cycle: op_sel increments, the flag clears, and the FSM goes to EXEC.
- **step press** in LOAD_A, LOAD_B or EXEC is dropped.
- **clr press** in any state → IDLE on the next edge. It clears the pending flag; op_sel is retained.
- **Priority for simultaneous presses:** clr > step > op. In SHOW, step+op goes to LOAD_A and still increments op_sel. In IDLE/WAIT_B, op alongside step increments op_sel as usual.
- **Op encoding** (package): 0 ADD, 1 SUB, 2 AND, 3 OR.

## Timing
- **Reset values:**
  - state=IDLE
  - op_sel=0
  - load_a=load_b=exec=result_valid=0
  - sync flops, debounced levels, counters and pending flag all 0
- **Press latency.** Raw button high and held from before edge k:
  - press pulse is high in the cycle after edge k+1+DB_CYCLES,
  - the FSM/op_sel reaction is visible after edge k+2+DB_CYCLES.
- **Bounces:** a glitch shorter than DB_CYCLES synced cycles never produces a pulse. A hold of exactly DB_CYCLES cycles produces one pulse.
- **Step→compute chain:** step in WAIT_B gives load_b in cycle n+1, exec in n+2, result_valid from n+3 onward.
- **Mid-operation reset:** rst asserted in any cycle forces the reset values at that edge. A button held through reset is re-debounced from zero and produces one pulse.

## Structure
- Package calc_pkg holds the state enum (3-bit), the op code localparams and the width constant OP_W=2.
- Sub-module pb_debounce (synchronizer + counter + edge pulse, parameter DB_CYCLES) is instantiated three times.
- The FSM, op_sel counter and pending flag live in calc_sequencer.

## Test plan
- **Reset and idle:** rst for 2 cycles → all outputs 0, state=0. Each of 4 op presses → op_sel 1,2,3,0.
- **Debounce** (DB_CYCLES=16): bounce pb_step with a 5-on/3-off pattern ×4, then a clean hold of 20 cycles → exactly one load_a, arriving 18 edges after the stable rise.
- **Full sequence:** step, step → load_a, then load_b, exec on consecutive cycles, then result_valid=1. A further step → load_a, result_valid=0.
- **Re-execute and pending:**
  - op in SHOW with op_sel=1 → op_sel=2, one exec pulse, back to SHOW.
  - op landing in the LOAD_B cycle → op_sel unchanged through exec, then incremented plus a second exec.
- **Priority/clear:**
  - step+op+clr in the same cycle in WAIT_B → IDLE, op_sel unchanged, no strobes.
  - step+op in SHOW → LOAD_A, op_sel+1.
- **Mid-op reset:** rst in the EXEC cycle → exec low next cycle, state=IDLE, op_sel=0, with pb_step held → one load_a after re-debounce.
